// File: rtl/mbus_bridge_pkg.sv
// Shared definitions for the host memory-bus bridge: FSM encoding,
// strobe idle level and default widths.
package mbus_bridge_pkg;

    // Encoding is visible on the STATE debug output, so values are fixed.
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_STROBE  = 3'd2,
        S_CAPTURE = 3'd3,
        S_RELEASE = 3'd4
    } state_t;

    localparam logic        STROBE_OFF  = 1'b1;
    localparam int unsigned DEF_DW      = 16;
    localparam int unsigned DEF_TIMEOUT = 1023;

endpackage

// File: rtl/mbus_bridge_if.sv
// Core-side request/response signals and host-side MBUS pins of the bridge.
// master = the bridge itself, slave = the core plus host/pad environment.
interface mbus_bridge_if #(
    parameter int unsigned DW = mbus_bridge_pkg::DEF_DW
) ();

    // core side
    logic          mread;
    logic          mwrite;
    logic          mword;
    logic [DW-1:0] md;
    logic [DW-1:0] mq;
    logic          mdone;
    logic          merr;
    logic          intrq;
    logic [2:0]    state;

    // host side, active-low
    logic          mread_n;
    logic          mwrite_n;
    logic          mword_n;
    logic [DW-1:0] bus_o;
    logic          bus_oe;
    logic [DW-1:0] bus_i;
    logic          dena_n;
    logic          ack_n;
    logic          intrq_n;

    modport master (
        input  mread, mwrite, mword, md, bus_i, dena_n, ack_n, intrq_n,
        output mq, mdone, merr, intrq, state,
               mread_n, mwrite_n, mword_n, bus_o, bus_oe
    );

    modport slave (
        output mread, mwrite, mword, md, bus_i, dena_n, ack_n, intrq_n,
        input  mq, mdone, merr, intrq, state,
               mread_n, mwrite_n, mword_n, bus_o, bus_oe
    );

endinterface

// File: rtl/mbus_bridge_sync_bit.sv
// Multi-stage synchroniser for one asynchronous host input.
module sync_bit #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Shift the raw input through the chain; reset to the inactive level.
    always_ff @(posedge clk) begin
        if (rst) chain <= {STAGES{RESET_VAL}};
        else     chain <= {chain[STAGES-2:0], d};
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/mbus_bridge.sv
// Registered transfer engine between the core and the active-low host MBUS.
// Each core request becomes one strobe/acknowledge cycle, with contention
// guard on the pad enable and an optional strobe timeout.
module mbus_bridge
    import mbus_bridge_pkg::*;
#(
    parameter int unsigned DW      = DEF_DW,
    parameter int unsigned SYNC    = 2,
    parameter int unsigned SETUP   = 1,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT,
    parameter int unsigned TO_W    = 10
) (
    input  logic          CLOCK,
    input  logic          RESET,
    mbus_bridge_if.master bus
);

    localparam int unsigned    SU_W   = $clog2(SETUP + 1);
    localparam logic [SU_W-1:0] SU_LIM = SU_W'(SETUP - 1);
    localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT);

    logic dena_raw, ack_raw, intrq_raw;
    logic dena_s, ack_s;

    sync_bit #(.STAGES(SYNC), .RESET_VAL(1'b1)) u_sync_dena (
        .clk(CLOCK), .rst(RESET), .d(bus.dena_n), .q(dena_raw));
    sync_bit #(.STAGES(SYNC), .RESET_VAL(1'b1)) u_sync_ack (
        .clk(CLOCK), .rst(RESET), .d(bus.ack_n), .q(ack_raw));
    sync_bit #(.STAGES(SYNC), .RESET_VAL(1'b1)) u_sync_intrq (
        .clk(CLOCK), .rst(RESET), .d(bus.intrq_n), .q(intrq_raw));

    assign dena_s    = ~dena_raw;
    assign ack_s     = ~ack_raw;
    assign bus.intrq = ~intrq_raw;

    state_t          state, state_d;
    logic [TO_W-1:0] to_cnt;
    logic [SU_W-1:0] su_cnt;
    logic            is_write, word;
    logic [DW-1:0]   wdata;

    logic            mread_n_q, mwrite_n_q, mword_n_q, oe_q;
    logic [DW-1:0]   bus_o_q, mq_q;
    logic            mdone_q, merr_q;

    logic            done_d, err_d, strobe_d, oe_d, capture, latch, to_hit;

    // Next state and the per-cycle bus intent; outputs are registered from it.
    always_comb begin
        state_d  = state;
        done_d   = 1'b0;
        err_d    = 1'b0;
        strobe_d = 1'b0;
        oe_d     = 1'b0;
        capture  = 1'b0;
        latch    = 1'b0;
        to_hit   = (TIMEOUT != 0) && (to_cnt == TO_LIM);
        case (state)
            S_IDLE: begin
                if (bus.mread && bus.mwrite) begin
                    done_d = 1'b1;
                    err_d  = 1'b1;
                end else if (bus.mwrite) begin
                    latch   = 1'b1;
                    state_d = S_SETUP;
                end else if (bus.mread) begin
                    latch   = 1'b1;
                    state_d = S_STROBE;
                end
            end
            S_SETUP: begin
                oe_d = 1'b1;
                if (!dena_s && su_cnt == SU_LIM) state_d = S_STROBE;
            end
            S_STROBE: begin
                // Timeout is tested first so it wins over a same-cycle ack.
                if (to_hit) begin
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = S_RELEASE;
                end else if (is_write && ack_s) begin
                    done_d  = 1'b1;
                    state_d = S_RELEASE;
                end else if (!is_write && ack_s && dena_s) begin
                    state_d = S_CAPTURE;
                end else begin
                    strobe_d = 1'b1;
                    oe_d     = is_write;
                end
            end
            S_CAPTURE: begin
                capture = 1'b1;
                done_d  = 1'b1;
                state_d = S_RELEASE;
            end
            S_RELEASE: begin
                if (!ack_s) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge CLOCK) begin
        if (RESET) state <= S_IDLE;
        else       state <= state_d;
    end

    // Counters, request latches and registered bus/core outputs.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            to_cnt     <= '0;
            su_cnt     <= '0;
            is_write   <= 1'b0;
            word       <= 1'b0;
            wdata      <= '0;
            mread_n_q  <= STROBE_OFF;
            mwrite_n_q <= STROBE_OFF;
            mword_n_q  <= STROBE_OFF;
            oe_q       <= 1'b0;
            bus_o_q    <= '1;
            mq_q       <= '0;
            mdone_q    <= 1'b0;
            merr_q     <= 1'b0;
        end else begin
            to_cnt <= (state == S_STROBE) ? to_cnt + 1'b1 : '0;
            if (state != S_SETUP)  su_cnt <= '0;
            else if (!dena_s)      su_cnt <= su_cnt + 1'b1;
            if (latch) begin
                is_write <= bus.mwrite;
                word     <= bus.mword;
                if (bus.mwrite) wdata <= bus.md;
            end
            mread_n_q  <= ~(strobe_d & ~is_write);
            mwrite_n_q <= ~(strobe_d & is_write);
            mword_n_q  <= strobe_d ? ~word : STROBE_OFF;
            oe_q       <= oe_d;
            bus_o_q    <= oe_d ? ~wdata : '1;
            if (capture) mq_q <= ~bus.bus_i;
            mdone_q    <= done_d;
            merr_q     <= err_d;
        end
    end

    // The host owning the bus always overrides our enable.
    logic drive;
    assign drive        = oe_q & ~dena_s;
    assign bus.bus_oe   = drive;
    assign bus.bus_o    = drive ? bus_o_q : '1;
    assign bus.mread_n  = mread_n_q;
    assign bus.mwrite_n = mwrite_n_q;
    assign bus.mword_n  = mword_n_q;
    assign bus.mq       = mq_q;
    assign bus.mdone    = mdone_q;
    assign bus.merr     = merr_q;
    assign bus.state    = state;

endmodule

// File: tb/tb_mbus_bridge.sv
// Directed testbench for mbus_bridge: one default instance and one with
// TIMEOUT=8 for the timeout cases.
module tb_mbus_bridge;

    logic CLOCK;
    logic RESET;

    mbus_bridge_if #(.DW(16)) bus ();
    mbus_bridge_if #(.DW(16)) bus2 ();

    mbus_bridge #(.DW(16), .SYNC(2), .SETUP(1), .TIMEOUT(1023), .TO_W(10)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .bus(bus));
    mbus_bridge #(.DW(16), .SYNC(2), .SETUP(1), .TIMEOUT(8), .TO_W(4)) dut_to (
        .CLOCK(CLOCK), .RESET(RESET), .bus(bus2));

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int   k_oe, k_st, k_done, n_done, low_cnt;
    logic err_seen, oe_seen, st_seen, wlow_ok, whigh_ok, strobe_at_done;
    logic [15:0] bo, rq;

    initial begin
        RESET = 1'b1;
        bus.mread = 0;  bus.mwrite = 0;  bus.mword = 0;  bus.md = '0;
        bus.bus_i = '0; bus.dena_n = 1;  bus.ack_n = 1;  bus.intrq_n = 1;
        bus2.mread = 0; bus2.mwrite = 0; bus2.mword = 0; bus2.md = '0;
        bus2.bus_i = '0; bus2.dena_n = 1; bus2.ack_n = 1; bus2.intrq_n = 1;
        repeat (3) @(posedge CLOCK);
        @(negedge CLOCK);
        check("rst_strobes", {bus.mread_n, bus.mwrite_n, bus.mword_n}, 3'b111);
        check("rst_oe_bus_o", {bus.bus_oe, bus.bus_o}, {1'b0, 16'hFFFF});
        check("rst_core", {bus.mq, bus.mdone, bus.merr, bus.intrq}, 19'd0);
        check("rst_state", bus.state, 0);
        RESET = 1'b0;

        // write 1234, ack 5 cycles after strobe
        @(negedge CLOCK);
        bus.md = 16'h1234; bus.mword = 1; bus.mwrite = 1;
        @(posedge CLOCK);
        k_oe = -1; k_st = -1; k_done = -1; n_done = 0; err_seen = 0; bo = '0; wlow_ok = 1;
        for (int k = 0; k < 24; k++) begin
            @(negedge CLOCK);
            if (bus.bus_oe && k_oe < 0) begin k_oe = k; bo = bus.bus_o; end
            if (!bus.mwrite_n && k_st < 0) k_st = k;
            if (!bus.mwrite_n && bus.mword_n) wlow_ok = 0;
            if (bus.mdone) begin
                n_done++;
                if (k_done < 0) k_done = k;
                err_seen |= bus.merr;
                bus.mwrite = 0; bus.ack_n = 1;
            end
            if (k_st >= 0 && k == k_st + 5) bus.ack_n = 0;
        end
        bus.ack_n = 1;
        check("wr_oe_cycle", k_oe, 1);
        check("wr_strobe_cycle", k_st, 2);
        check("wr_bus_o", bo, 16'hEDCB);
        check("wr_mword_low", wlow_ok, 1);
        check("wr_done_cycle", k_done, 10);
        check("wr_done_count", n_done, 1);
        check("wr_merr", err_seen, 0);
        check("wr_idle", bus.state, 0);

        // word read, host drives 00FF
        @(negedge CLOCK);
        bus.dena_n = 0; bus.bus_i = 16'h00FF;
        repeat (3) @(negedge CLOCK);
        bus.mword = 1; bus.mread = 1;
        @(posedge CLOCK);
        k_st = -1; k_done = -1; n_done = 0; err_seen = 0; oe_seen = 0; wlow_ok = 1; rq = '0;
        for (int k = 0; k < 20; k++) begin
            @(negedge CLOCK);
            oe_seen |= bus.bus_oe;
            if (!bus.mread_n && k_st < 0) k_st = k;
            if (!bus.mread_n && bus.mword_n) wlow_ok = 0;
            if (bus.mdone) begin
                n_done++;
                if (k_done < 0) begin k_done = k; rq = bus.mq; end
                err_seen |= bus.merr;
                bus.mread = 0; bus.ack_n = 1;
            end
            if (k_st >= 0 && k == k_st + 2) bus.ack_n = 0;
        end
        bus.ack_n = 1;
        check("rd_strobe_cycle", k_st, 1);
        check("rd_mword_low", wlow_ok, 1);
        check("rd_done_cycle", k_done, 7);
        check("rd_mq", rq, 16'hFF00);
        check("rd_done_count", n_done, 1);
        check("rd_merr", err_seen, 0);
        check("rd_no_oe", oe_seen, 0);

        // byte write while host keeps the bus, then host releases it
        bus.mword = 0; bus.md = 16'hA55A; bus.mwrite = 1;
        @(posedge CLOCK);
        oe_seen = 0; st_seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge CLOCK);
            oe_seen |= bus.bus_oe;
            st_seen |= ~bus.mwrite_n;
        end
        check("dena_no_oe", oe_seen, 0);
        check("dena_no_strobe", st_seen, 0);
        check("dena_in_setup", bus.state, 1);
        bus.dena_n = 1;
        k_oe = -1; k_st = -1; n_done = 0; err_seen = 0; bo = '0; whigh_ok = 1;
        for (int k = 0; k < 24; k++) begin
            @(negedge CLOCK);
            if (bus.bus_oe && k_oe < 0) begin k_oe = k; bo = bus.bus_o; end
            if (!bus.mwrite_n && !bus.mword_n) whigh_ok = 0;
            if (!bus.mwrite_n && k_st < 0) begin k_st = k; bus.ack_n = 0; end
            if (bus.mdone) begin
                n_done++;
                err_seen |= bus.merr;
                bus.mwrite = 0; bus.ack_n = 1;
            end
        end
        bus.ack_n = 1;
        check("dena_oe_first", (k_oe >= 0) && (k_st > k_oe), 1);
        check("dena_bus_o", bo, 16'h5AA5);
        check("dena_byte_mword", whigh_ok, 1);
        check("dena_done_count", n_done, 1);
        check("dena_merr", err_seen, 0);
        check("mq_held", bus.mq, 16'hFF00);

        // reset in the middle of a read strobe
        @(negedge CLOCK);
        bus.mword = 0; bus.mread = 1;
        @(posedge CLOCK);
        repeat (3) @(negedge CLOCK);
        check("pre_rst_strobe", bus.mread_n, 0);
        RESET = 1'b1;
        @(posedge CLOCK);
        @(negedge CLOCK);
        check("midrst_strobes", {bus.mread_n, bus.mwrite_n, bus.mword_n}, 3'b111);
        check("midrst_oe_state", {bus.bus_oe, bus.state}, 4'd0);
        check("midrst_done_mq", {bus.mdone, bus.mq}, 17'd0);
        RESET = 1'b0; bus.mread = 0;
        repeat (3) @(negedge CLOCK);

        // simultaneous read and write is rejected without bus activity
        bus.mread = 1; bus.mwrite = 1;
        @(posedge CLOCK);
        @(negedge CLOCK);
        check("both_done_err", {bus.mdone, bus.merr}, 2'b11);
        check("both_bus_idle", {bus.mread_n, bus.mwrite_n, bus.bus_oe, bus.state}, {3'b110, 3'd0});
        bus.mread = 0; bus.mwrite = 0;
        @(posedge CLOCK);
        @(negedge CLOCK);
        check("both_done_pulse", bus.mdone, 0);

        // interrupt takes two cycles through the synchroniser
        bus.intrq_n = 0;
        @(posedge CLOCK);
        @(negedge CLOCK);
        check("intrq_stage1", bus.intrq, 0);
        @(posedge CLOCK);
        @(negedge CLOCK);
        check("intrq_stage2", bus.intrq, 1);
        bus.intrq_n = 1;

        // TIMEOUT=8, host never acknowledges
        bus2.mword = 0; bus2.mread = 1;
        @(posedge CLOCK);
        low_cnt = 0; k_done = -1; err_seen = 0; strobe_at_done = 0;
        for (int k = 0; k < 24; k++) begin
            @(negedge CLOCK);
            if (!bus2.mread_n) low_cnt++;
            if (bus2.mdone && k_done < 0) begin
                k_done = k; err_seen = bus2.merr; strobe_at_done = bus2.mread_n;
                bus2.mread = 0;
            end
        end
        check("to_low_cycles", low_cnt, 8);
        check("to_done_cycle", k_done, 9);
        check("to_merr", err_seen, 1);
        check("to_strobe_high", strobe_at_done, 1);
        check("to_idle", bus2.state, 0);

        // ack reaching the FSM on the timeout cycle loses to the timeout
        bus2.dena_n = 0;
        repeat (3) @(negedge CLOCK);
        bus2.mread = 1;
        @(posedge CLOCK);
        k_done = -1; err_seen = 0;
        for (int k = 0; k < 24; k++) begin
            @(negedge CLOCK);
            if (k == 6) bus2.ack_n = 0;
            if (bus2.mdone && k_done < 0) begin
                k_done = k; err_seen = bus2.merr;
                bus2.mread = 0; bus2.ack_n = 1;
            end
        end
        bus2.ack_n = 1; bus2.dena_n = 1;
        check("tie_done_cycle", k_done, 9);
        check("tie_merr", err_seen, 1);
        check("tie_idle", bus2.state, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
